// File: rtl/clint_bram.sv
// rtl/clint_bram.sv - single-clock CLINT (msip/mtime/mtimecmp) behind a 64KiB BRAM-style port
// Optional macro CLINT_MTIME_WR_EN makes the mtime halves writable.
module clint_bram #(
    parameter int NUM_HARTS = 1,
    parameter int TICK_DIV  = 40
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [15:0]          bram_addr,
    input  logic                 bram_en,
    input  logic [3:0]           bram_we,
    input  logic [31:0]          bram_wrdata,
    output logic [31:0]          bram_rddata,
    output logic [NUM_HARTS-1:0] msip,
    output logic [NUM_HARTS-1:0] mtip
);

    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);

    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    logic [15:0]          presc_q, presc_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q, msip_d;
    logic [NUM_HARTS-1:0] mtip_q, mtip_d;
    logic [31:0]          rddata_q, rddata_d;

    logic [15:0] word;
    logic        wr, tick, in_msip, in_cmp;
    logic [11:0] msip_idx, cmp_idx;
    logic [31:0] rd_val;

    assign word     = bram_addr & 16'hFFFC;
    assign wr       = bram_en && (bram_we != 4'b0000);
    assign tick     = (presc_q == TICK_MAX);
    assign in_msip  = (word < 16'h4000);
    assign in_cmp   = (word >= 16'h4000) && (word < 16'hBFF8);
    assign msip_idx = 12'(word >> 2);
    assign cmp_idx  = 12'((word - 16'h4000) >> 3);

    // Read mux sees only current register values, which makes same-cycle read/write read-first.
    always_comb begin
        rd_val = 32'h0;
        if (word == 16'hBFF8) rd_val = mtime_q[31:0];
        if (word == 16'hBFFC) rd_val = mtime_q[63:32];
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (in_msip && msip_idx == 12'(i)) rd_val = {31'b0, msip_q[i]};
            if (in_cmp && cmp_idx == 12'(i))
                rd_val = word[2] ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
        end
    end

    always_comb begin
        presc_d    = tick ? 16'h0 : presc_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
`ifdef CLINT_MTIME_WR_EN
        // A write overrides the tick for the whole 64-bit counter in that cycle.
        if (wr && word == 16'hBFF8)
            mtime_d = {mtime_q[63:32], merge32(mtime_q[31:0], bram_wrdata, bram_we)};
        if (wr && word == 16'hBFFC)
            mtime_d = {merge32(mtime_q[63:32], bram_wrdata, bram_we), mtime_q[31:0]};
`endif
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtip_d     = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (wr && in_msip && msip_idx == 12'(i) && bram_we[0])
                msip_d[i] = bram_wrdata[0];
            if (wr && in_cmp && cmp_idx == 12'(i)) begin
                if (word[2])
                    mtimecmp_d[i][63:32] = merge32(mtimecmp_q[i][63:32], bram_wrdata, bram_we);
                else
                    mtimecmp_d[i][31:0]  = merge32(mtimecmp_q[i][31:0], bram_wrdata, bram_we);
            end
            mtip_d[i] = (mtime_q >= mtimecmp_q[i]);
        end
        rddata_d   = bram_en ? rd_val : rddata_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q  <= '0;
            mtime_q  <= '0;
            msip_q   <= '0;
            mtip_q   <= '0;
            rddata_q <= '0;
            for (int i = 0; i < NUM_HARTS; i++)
                mtimecmp_q[i] <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            rddata_q   <= rddata_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign bram_rddata = rddata_q;
    assign msip        = msip_q;
    assign mtip        = mtip_q;

endmodule

// File: doc/clint_bram.md
Name: clint_bram

Overview:
- Parametrised single-clock CLINT with a 64KiB BRAM-style slave port. Provides per-hart software (msip) and timer (mtip) interrupts.
- mtime advances on an internal prescaled tick derived from clk, so there is no separate timer clock domain.
- Honours per-byte write enables. A full-word-only write mode is not supported.
- Sits behind the BRAM controller on the peripheral interconnect and drives the interrupt inputs of every hart.

Parameters:
- NUM_HARTS, 1, number of harts; legal range 1..4095.
- TICK_DIV, 40, clk cycles per mtime increment; legal range 1..65535. With the 40MHz clk this gives a 1MHz mtime.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- bram_addr  input  16  byte address; bits [1:0] are ignored
- bram_en  input  1  access strobe
- bram_we  input  4  per-byte write enable; nonzero together with bram_en means a write
- bram_wrdata  input  32  write data
- bram_rddata  output  32  read data, 1-cycle latency
- msip  output  NUM_HARTS  machine software interrupt, one bit per hart
- mtip  output  NUM_HARTS  machine timer interrupt, one bit per hart

Behaviour:
- Reset (async assert, sync release):
  - msip=0, mtip=0, mtime=0, prescaler=0, bram_rddata=0.
  - Every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
- Address map (word aligned). Any other address reads 0 and ignores writes.
  - 0x0000+4*i: msip[i]. Only bit 0 is implemented; the other bits read 0.
  - 0x4000+8*i: mtimecmp[i][31:0].
  - 0x4004+8*i: mtimecmp[i][63:32].
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
  - Valid hart index: i < NUM_HARTS.
- Write timing:
  - bram_en=1 and bram_we[b]=1 updates byte b of the addressed register at the clk edge.
  - For msip, only bram_we[0] with bram_wrdata[0] has an effect.
- Read timing:
  - bram_en=1 latches the addressed register into bram_rddata at the edge, giving data on the next cycle.
  - bram_en=0 holds bram_rddata.
  - A read and write to the same address in one cycle returns the old value (read-first).
- Prescaler:
  - Counts 0..TICK_DIV-1. On the edge where it equals TICK_DIV-1 it wraps to 0 and raises a one-cycle tick.
  - TICK_DIV=1 ticks every cycle.
- mtime:
  - Increments by 1 on each tick and wraps from 2^64-1 to 0.
  - The carry between halves is atomic within one cycle.
  - A write to either mtime half in the same cycle as a tick wins: the written bytes take the write data, and that whole mtime (both halves) is not incremented on that cycle.
- mtip:
  - Registered: mtip[i] <= (mtime >= mtimecmp[i]), an unsigned 64-bit compare of current register values.
  - Updates one cycle after any change to mtime or mtimecmp. It is level, not sticky.
  - Writing mtimecmp above mtime drops mtip 1 cycle after the write edge.
- msip:
  - Driven directly from its register, so the interrupt is visible the cycle after the write edge.
- Reset mid-operation:
  - All state returns to reset values immediately. An in-flight read is discarded and bram_rddata=0.

Optional Feature:
- Macro: CLINT_MTIME_WR_EN.
- Defined: mtime halves are writable as described above.
- Undefined: writes to 0xBFF8/0xBFFC are ignored (reads still work) and mtime is only altered by ticks and reset. This removes the write/tick priority path.

Test Plan:
- Reset value check: assert rstn=0, then release. Read 0xBFF8 → 0, 0x4000 → 0xFFFFFFFF, 0x4004 → 0xFFFFFFFF. mtip=0 and msip=0.
- msip set and clear:
  - Write 0x0004 data=1, we=4'b0001 (NUM_HARTS=2) → msip=2'b10 next cycle.
  - Write the same data with we=4'b0010 → no change.
  - Write data=0, we=4'b0001 → msip=0.
- Prescaler rate: TICK_DIV=4, idle 40 cycles after reset → read 0xBFF8 = 10.
- Timer interrupt, low half: mtimecmp[0] = {0x0,0x5}, TICK_DIV=1 → mtip[0] rises exactly 1 cycle after mtime becomes 5. Then write 0x4000=0x100 → mtip[0] falls 1 cycle after the write.
- Carry and wrap, with CLINT_MTIME_WR_EN defined:
  - Write mtime = 0x00000000_FFFFFFFF → after one tick read 0xBFFC = 1, 0xBFF8 = 0.
  - Write mtime = 2^64-1 → next tick wraps to 0.
  - Write in a tick cycle → the written value persists with no +1 on that cycle.
- Byte enables and unmapped space:
  - Write 0x4000 data=0xAABBCCDD, we=4'b0101 over 0xFFFFFFFF → reads 0xFFBBFFDD.
  - Read 0x4010 with NUM_HARTS=2 → 0.
  - Read 0x8000 → 0.
  - With the macro undefined, write 0xBFF8 → mtime unaffected.
